// File: rtl/mult_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module  : mult_control_unit_if
//  Brief   : Start/done handshake and datapath strobes of the shift-add
//            multiplier controller.
//  Revision: 1.0  initial release
// ============================================================================
interface mult_control_unit_if #(
    parameter int BITS = 8
);
    localparam int CW = $clog2(BITS + 1);

    logic          start;
    logic          abort;
    logic          q0;
    logic          q_en;
    logic          q_ls;
    logic          m_en;
    logic          a_clr;
    logic          a_add;
    logic          a_shift;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    // Controller side: drives the datapath strobes and status.
    modport master (
        input  start, abort, q0,
        output q_en, q_ls, m_en, a_clr, a_add, a_shift, busy, done, cnt
    );

    // System/datapath side.
    modport slave (
        output start, abort, q0,
        input  q_en, q_ls, m_en, a_clr, a_add, a_shift, busy, done, cnt
    );
endinterface
`default_nettype wire

// File: rtl/mult_control_unit.sv
`default_nettype none
// ============================================================================
//  Module  : mult_control_unit
//  Brief   : FSM and iteration counter sequencing BITS add/shift steps of a
//            shift-add multiplier datapath.
//  Revision: 1.0  initial release
// ============================================================================
module mult_control_unit #(
    parameter int BITS = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mult_control_unit_if.master  bus
);
    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_en_q, q_en_d;
    logic          q_ls_q, q_ls_d;
    logic          m_en_q, m_en_d;
    logic          a_clr_q, a_clr_d;
    logic          a_shift_q, a_shift_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          w_active;

    assign w_active = (state_q == S_LOAD) || (state_q == S_EVAL) || (state_q == S_SHIFT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  begin
                state_d = S_EVAL;
                cnt_d   = CW'(BITS);
            end
            S_EVAL:  state_d = S_SHIFT;
            S_SHIFT: begin
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == CW'(1)) ? S_DONE : S_EVAL;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every transition, including SHIFT -> DONE.
        if (bus.abort && w_active) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end

        // Moore outputs are decoded from the next state so they come from flops.
        q_en_d    = (state_d == S_LOAD) || (state_d == S_SHIFT);
        q_ls_d    = (state_d == S_SHIFT);
        m_en_d    = (state_d == S_LOAD);
        a_clr_d   = (state_d == S_LOAD);
        a_shift_d = (state_d == S_SHIFT);
        busy_d    = (state_d == S_LOAD) || (state_d == S_EVAL) || (state_d == S_SHIFT);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            q_en_q    <= 1'b0;
            q_ls_q    <= 1'b0;
            m_en_q    <= 1'b0;
            a_clr_q   <= 1'b0;
            a_shift_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_en_q    <= q_en_d;
            q_ls_q    <= q_ls_d;
            m_en_q    <= m_en_d;
            a_clr_q   <= a_clr_d;
            a_shift_q <= a_shift_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.q_en    = q_en_q;
    assign bus.q_ls    = q_ls_q;
    assign bus.m_en    = m_en_q;
    assign bus.a_clr   = a_clr_q;
    assign bus.a_shift = a_shift_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.cnt     = cnt_q;
    // Only Mealy output: the add decision follows the live Q[0].
    assign bus.a_add   = (state_q == S_EVAL) && bus.q0;

endmodule
`default_nettype wire

// File: tb/tb_mult_control_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mult_control_unit
//  Brief   : Directed self-checking bench with behavioural A/Q/M datapaths.
//  Revision: 1.0  initial release
// ============================================================================
module tb_mult_control_unit;
    logic clk;
    logic rst_n;
    int   vectors;
    int   fails;

    logic [7:0] mplier, mcand;
    logic [3:0] mplier4, mcand4;

    mult_control_unit_if #(.BITS(8)) if8 ();
    mult_control_unit_if #(.BITS(4)) if4 ();

    mult_control_unit #(.BITS(8)) u_dut8 (.clk(clk), .rst(rst_n), .bus(if8));
    mult_control_unit #(.BITS(4)) u_dut4 (.clk(clk), .rst(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath models: A carries one extra bit for the add carry.
    logic [8:0] a8;
    logic [7:0] q8, m8;
    logic [4:0] a4;
    logic [3:0] q4, m4;

    always @(posedge clk) begin
        if (if8.m_en) m8 <= mcand;
        if (if8.a_clr)        a8 <= '0;
        else if (if8.a_add)   a8 <= a8 + {1'b0, m8};
        else if (if8.a_shift) a8 <= a8 >> 1;
        if (if8.q_en) q8 <= if8.q_ls ? {a8[0], q8[7:1]} : mplier;
    end
    assign if8.q0 = q8[0];

    always @(posedge clk) begin
        if (if4.m_en) m4 <= mcand4;
        if (if4.a_clr)        a4 <= '0;
        else if (if4.a_add)   a4 <= a4 + {1'b0, m4};
        else if (if4.a_shift) a4 <= a4 >> 1;
        if (if4.q_en) q4 <= if4.q_ls ? {a4[0], q4[3:1]} : mplier4;
    end
    assign if4.q0 = q4[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs8();
        return {if8.q_en, if8.q_ls, if8.m_en, if8.a_clr,
                if8.a_add, if8.a_shift, if8.busy, if8.done};
    endfunction

    // Launch one BITS=8 operation from IDLE and observe it through edge 20.
    task automatic run_op(input logic [7:0] mr, input logic [7:0] md,
                          output int adds, output int shifts, output int busy_cyc,
                          output int ndone, output int done_edge);
        mplier = mr; mcand = md;
        adds = 0; shifts = 0; busy_cyc = 0; ndone = 0; done_edge = -1;
        if8.start = 1'b1;
        for (int e = 0; e <= 20; e++) begin
            @(posedge clk); #1;
            if (e == 0) if8.start = 1'b0;
            if (if8.a_add)   adds++;
            if (if8.a_shift) shifts++;
            if (if8.busy)    busy_cyc++;
            if (if8.done) begin ndone++; done_edge = e; end
        end
    endtask

    int adds, shifts, busy_cyc, ndone, done_edge, last, cnt_ev;

    initial begin
        vectors = 0; fails = 0;
        rst_n = 1'b0;
        if8.start = 1'b0; if8.abort = 1'b0;
        if4.start = 1'b0; if4.abort = 1'b0;
        mplier = '0; mcand = '0; mplier4 = '0; mcand4 = '0;

        #12;
        check("reset_outputs", {24'h0, outs8()}, 32'h0);
        check("reset_cnt", {28'h0, if8.cnt}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 13 x 11
        run_op(8'd11, 8'd13, adds, shifts, busy_cyc, ndone, done_edge);
        check("p13x11", {16'h0, a8[7:0], q8}, 32'd143);
        check("p13x11_done_count", ndone, 1);
        check("p13x11_done_edge", done_edge, 17);
        check("p13x11_busy_cycles", busy_cyc, 17);
        check("p13x11_adds", adds, 3);

        // 0xA5 x 0xFF
        run_op(8'hA5, 8'hFF, adds, shifts, busy_cyc, ndone, done_edge);
        check("pA5xFF_adds", adds, 4);
        check("pA5xFF_shifts", shifts, 8);
        check("pA5xFF", {16'h0, a8[7:0], q8}, 32'hA45B);

        // Multiplier zero
        run_op(8'h00, 8'h77, adds, shifts, busy_cyc, ndone, done_edge);
        check("p0_adds", adds, 0);
        check("p0_done_edge", done_edge, 17);
        check("p0_product", {16'h0, a8[7:0], q8}, 32'h0);

        // Abort in the 3rd SHIFT (entered on edge 6)
        mplier = 8'h3C; mcand = 8'h21;
        if8.start = 1'b1;
        @(posedge clk); #1; if8.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort_in_shift", {31'h0, if8.a_shift}, 32'h1);
        check("abort_cnt_before", {28'h0, if8.cnt}, 32'd6);
        if8.abort = 1'b1;
        @(posedge clk); #1; if8.abort = 1'b0;
        check("abort_busy", {31'h0, if8.busy}, 32'h0);
        check("abort_cnt", {28'h0, if8.cnt}, 32'h0);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (if8.done) ndone++;
            @(posedge clk); #1;
        end
        check("abort_no_done", ndone, 0);
        run_op(8'd9, 8'd7, adds, shifts, busy_cyc, ndone, done_edge);
        check("p7x9", {16'h0, a8[7:0], q8}, 32'd63);
        check("p7x9_done_edge", done_edge, 17);

        // Asynchronous reset mid-operation
        if8.start = 1'b1;
        @(posedge clk); #1; if8.start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_outputs", {24'h0, outs8()}, 32'h0);
        check("midreset_cnt", {28'h0, if8.cnt}, 32'h0);
        #3 rst_n = 1'b1;
        busy_cyc = 0; ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (if8.busy) busy_cyc++;
            if (if8.done) ndone++;
        end
        check("post_reset_idle_busy", busy_cyc, 0);
        check("post_reset_idle_done", ndone, 0);

        // start held high for 60 cycles
        mplier = 8'h5A; mcand = 8'h33;
        if8.start = 1'b1; last = -1; cnt_ev = 0;
        for (int e = 0; e < 60; e++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                if (last >= 0) check("held_done_gap", e - last, 19);
                last = e;
                cnt_ev++;
            end
        end
        if8.start = 1'b0;
        check("held_done_count", cnt_ev, 3);
        repeat (25) @(posedge clk);
        #1;

        // BITS=4: 15 x 15
        mplier4 = 4'd15; mcand4 = 4'd15; done_edge = -1;
        if4.start = 1'b1;
        for (int e = 0; e <= 12; e++) begin
            @(posedge clk); #1;
            if (e == 0) if4.start = 1'b0;
            if (if4.done) done_edge = e;
        end
        check("b4_p15x15", {24'h0, a4[3:0], q4}, 32'd225);
        check("b4_done_edge", done_edge, 9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mult_control_unit.md
# mult_control_unit

Sequencing controller for the shift-add multiplier datapath. It drives the multiplier Q register (parallel-load / right-shift / enable), the multiplicand M register and the accumulator A. It runs exactly BITS add/shift iterations per operation, using a start/done handshake toward the system. It contains the FSM and the iteration counter only; all arithmetic stays in the datapath.

## Interface
- BITS, 8, operand width (≥2); iteration count per operation
- CW, $clog2(BITS+1), width of iteration counter (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a multiplication; sampled only in IDLE
- abort  in  1  cancel current operation; sampled in LOAD/EVAL/SHIFT
- q0  in  1  current Q[0] (serial output of Q register), registered in datapath
- q_en  out  1  Q register enable
- q_ls  out  1  Q load/shift select: 0 = parallel load, 1 = shift right
- m_en  out  1  load multiplicand register M
- a_clr  out  1  clear accumulator A
- a_add  out  1  A <= A + M this cycle
- a_shift  out  1  shift A right; A[0] feeds Q's serial input D
- busy  out  1  high in LOAD, EVAL, SHIFT
- done  out  1  one-cycle completion pulse
- cnt  out  CW  remaining iterations

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, DONE. Encoding is free.
- IDLE: all strobes 0, busy=0. start=1 → LOAD.
- LOAD (1 cycle): q_en=1, q_ls=0, m_en=1, a_clr=1; cnt <= BITS. → EVAL.
- EVAL (1 cycle): a_add = q0. This is the only Mealy output; all others are Moore. → SHIFT.
- SHIFT (1 cycle): a_shift=1, q_en=1, q_ls=1; cnt <= cnt-1. If cnt==1 (last iteration) → DONE, else → EVAL.
- DONE (1 cycle): done=1, cnt holds 0. → IDLE unconditionally. Operand outputs remain in A:Q.
- abort=1 in LOAD/EVAL/SHIFT: next state IDLE, cnt <= 0, no done. Strobes of the current cycle still follow the current state. The datapath contents are then undefined.
- start while busy or in DONE: ignored, not queued.
- start held high continuously: a new operation launches from each IDLE visit.
- Precedence in SHIFT with cnt==1: abort wins over the transition to DONE.
- Outputs not listed for a state are 0 in that state. In every state, q_ls=0 whenever q_en=0.

## Timing
- Reset (rst=0, async): state=IDLE, cnt=0, every output 0 immediately, without waiting for a clock edge. Deassertion is sampled on the next rising edge. Reset mid-operation discards the operation, and no done is issued.
- Edge numbering: edge 0 is the rising edge that samples start=1 in IDLE; LOAD is active in the cycle after it.
- EVAL is entered on edge 2i−1 and SHIFT on edge 2i, for i = 1..BITS.
- done is high in the cycle after edge 2·BITS+1 (BITS=8: edge 17) and low again after edge 2·BITS+2.
- Earliest next accepted start is on edge 2·BITS+3, which gives a throughput of 2·BITS+3 cycles per operation.
- a_add per operation equals popcount(multiplier). a_shift, and q_en with q_ls=1, each occur exactly BITS times.
- q0 must be stable before the clock edge that ends EVAL. It reflects Q after the preceding SHIFT, or after LOAD for the first iteration.

## Test plan
- Reset: assert rst=0 asynchronously mid-cycle → all outputs 0 and cnt=0 before the next edge; after release with start=0, the block stays idle for 10 cycles.
- Multiply: BITS=8 with a behavioural A/Q/M datapath model, 13×11 → A:Q = 143, done pulses exactly once after edge 17, and busy is high for 17 cycles.
- Multiplier 0xA5, multiplicand 0xFF → exactly 4 a_add pulses and 8 a_shift pulses; product 0xA45B.
- Multiplier 0 → zero a_add pulses, done still after edge 17, and product 0.
- abort=1 in the 3rd SHIFT → IDLE next cycle, cnt=0, no done. A fresh start then runs a full operation, and 7×9 gives 63.
- start held high for 60 cycles → done pulses spaced exactly 19 cycles apart. BITS=4 rerun: 15×15 = 225, with done after edge 9.
